// File: rtl/dm_pkg.sv
// Shared definitions for the handshaked data memory: width codes, FSM states
// and the access legality check.
package dm_pkg;

    localparam logic [1:0] WIDTH_WORD = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_BYTE = 2'b10;
    localparam logic [1:0] WIDTH_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when the access is naturally aligned, uses a defined width and
    // stays inside the 2**(depth_log2+2)-byte window.
    function automatic logic addr_ok(input logic [1:0] width,
                                     input logic [31:0] addr,
                                     input int depth_log2);
        logic ok;
        ok = 1'b1;
        case (width)
            WIDTH_WORD: if (addr[1:0] != 2'b00) ok = 1'b0;
            WIDTH_HALF: if (addr[0] != 1'b0) ok = 1'b0;
            WIDTH_RSVD: ok = 1'b0;
            default:    ;
        endcase
        if ((addr >> (depth_log2 + 2)) != 32'd0) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering: store lane enables/replicated write word,
// and load lane extraction with sign or zero extension.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  lane_en,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [7:0]  raw_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign raw_byte[gi] = raw[8*gi +: 8];
    end

    assign sel_byte = raw_byte[addr_lo];
    assign sel_half = addr_lo[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        lane_en = 4'b0000;
        wword   = 32'd0;
        rdata   = 32'd0;
        case (width)
            WIDTH_WORD: begin
                lane_en = 4'b1111;
                wword   = wdata;
                rdata   = raw;
            end
            WIDTH_HALF: begin
                lane_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
                rdata   = {{16{sign & sel_half[15]}}, sel_half};
            end
            WIDTH_BYTE: begin
                lane_en = 4'b0001 << addr_lo;
                wword   = {4{wdata[7:0]}};
                rdata   = {{24{sign & sel_byte[7]}}, sel_byte};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_hs_unit.sv
// Data memory with valid/ready request and response handshakes, fixed access
// latency, byte-lane stores/loads and error reporting for illegal accesses.
module dm_hs_unit
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;

    logic        lat_we_reg;
    logic [1:0]  lat_width_reg;
    logic        lat_sign_reg;
    logic [31:0] lat_addr_reg;
    logic [31:0] lat_wdata_reg;

    logic        resp_err_reg;
    logic [31:0] resp_rdata_reg;

    logic        accept;
    logic        commit;
    logic        cur_we;
    logic [1:0]  cur_width;
    logic        cur_sign;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_ok;
    logic [DEPTH_LOG2-1:0] word_idx;

    logic [31:0] raw;
    logic [3:0]  lane_en;
    logic [31:0] wword;
    logic [31:0] ld_data;

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

    assign accept = req_valid && req_ready;
    assign commit = (state_next == RESP) && (state_reg != RESP);

    // With single-cycle latency the commit edge is also the acceptance edge,
    // so the live inputs are used before they have been latched.
    assign cur_we    = (state_reg == IDLE) ? req_we    : lat_we_reg;
    assign cur_width = (state_reg == IDLE) ? req_width : lat_width_reg;
    assign cur_sign  = (state_reg == IDLE) ? req_sign  : lat_sign_reg;
    assign cur_addr  = (state_reg == IDLE) ? req_addr  : lat_addr_reg;
    assign cur_wdata = (state_reg == IDLE) ? req_wdata : lat_wdata_reg;

    assign cur_ok   = addr_ok(cur_width, cur_addr, DEPTH_LOG2);
    assign word_idx = cur_addr[DEPTH_LOG2+1:2];

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        count_next = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (count_reg == 4'd1) begin
                    state_next = RESP;
                    count_next = 4'd0;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= 4'd0;
            lat_we_reg     <= 1'b0;
            lat_width_reg  <= WIDTH_WORD;
            lat_sign_reg   <= 1'b0;
            lat_addr_reg   <= 32'd0;
            lat_wdata_reg  <= 32'd0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (accept) begin
                lat_we_reg    <= req_we;
                lat_width_reg <= req_width;
                lat_sign_reg  <= req_sign;
                lat_addr_reg  <= req_addr;
                lat_wdata_reg <= req_wdata;
            end
            if (commit) begin
                resp_err_reg   <= !cur_ok;
                resp_rdata_reg <= (cur_ok && !cur_we) ? ld_data : 32'd0;
            end
        end
    end

    // One byte-wide array per lane so each lane's write enable stays local.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        assign raw[8*gi +: 8] = lane_mem[word_idx];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int w = 0; w < DEPTH; w++) lane_mem[w] <= 8'd0;
            end else if (commit && cur_we && cur_ok && lane_en[gi]) begin
                lane_mem[word_idx] <= wword[8*gi +: 8];
            end
        end
    end

    dm_lane_align u_align (
        .width   (cur_width),
        .addr_lo (cur_addr[1:0]),
        .sign    (cur_sign),
        .wdata   (cur_wdata),
        .raw     (raw),
        .lane_en (lane_en),
        .wword   (wword),
        .rdata   (ld_data)
    );

endmodule
